// File: rtl/hit_judge_pkg.sv
// hit_judge_pkg: shared definitions for the rhythm-game hit judge.
//   - lane FSM state encoding
//   - per-lane judgement result struct
//   - point values and score/combo saturation limits
//   - small popcount helper used by the accumulator
package hit_judge_pkg;

  localparam int NUM_LANES = 4;
  localparam int SCORE_W   = 16;
  localparam int COMBO_W   = 10;

  typedef enum logic {
    LANE_IDLE   = 1'b0,
    LANE_ACTIVE = 1'b1
  } lane_state_e;

  // At most one field is set per lane per cycle.
  typedef struct packed {
    logic perf;
    logic good;
    logic miss;
  } judge_t;

  localparam int PTS_PERF = 3;
  localparam int PTS_GOOD = 1;
  localparam int PTS_MISS = 0;

  localparam logic [SCORE_W-1:0] SCORE_MAX = 16'd65535;
  localparam logic [COMBO_W-1:0] COMBO_MAX = 10'd999;

  function automatic logic [2:0] popcnt4(input logic [3:0] v);
    return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

endpackage

// File: rtl/hit_judge_lane.sv
// hit_lane: one lane of the hit judge. Holds the IDLE/ACTIVE FSM and the
// tick counter C for the note currently in flight on this lane.
// Ports:
//   i_clk, i_rst_n  clock, async active-low reset
//   i_clr           synchronous game restart
//   i_tick          judgement tick strobe from the shared prescaler
//   i_btn           debounced press pulse for this lane
//   i_note          note issued on this lane this cycle
//   o_res           registered perf/good/miss pulse (one cycle long)
module hit_lane
  import hit_judge_pkg::*;
#(
  parameter int PERF_W = 30,
  parameter int GOOD_W = 80,
  parameter int CW     = 8
) (
  input  logic   i_clk,
  input  logic   i_rst_n,
  input  logic   i_clr,
  input  logic   i_tick,
  input  logic   i_btn,
  input  logic   i_note,
  output judge_t o_res
);

  localparam logic [CW-1:0] L_GOOD = CW'(GOOD_W);
  localparam logic [CW-1:0] L_PERF = CW'(PERF_W);
  localparam logic [CW-1:0] L_LAST = CW'(2 * GOOD_W);

  lane_state_e   r_state, w_state_nx;
  logic [CW-1:0] r_c, w_c_nx, w_err;
  judge_t        r_res, w_res;

  // Distance from the target time, in ticks.
  assign w_err = (r_c >= L_GOOD) ? (r_c - L_GOOD) : (L_GOOD - r_c);

  always_comb begin
    w_state_nx = r_state;
    w_c_nx     = r_c;
    w_res      = '0;
    case (r_state)
      LANE_IDLE: ;  // presses with nothing in flight are ignored
      LANE_ACTIVE: begin
        // Press wins over a coincident tick or new note.
        if (i_btn) begin
          if (w_err <= L_PERF) w_res.perf = 1'b1;
          else                 w_res.good = 1'b1;
          w_state_nx = LANE_IDLE;
        end else if (i_note) begin
          w_res.miss = 1'b1;  // old note displaced by a new one
        end else if (i_tick) begin
          if (r_c == L_LAST) begin
            w_res.miss = 1'b1;
            w_state_nx = LANE_IDLE;
          end else begin
            w_c_nx = r_c + 1'b1;
          end
        end
      end
      default: ;
    endcase
    // A new note always (re)starts the lane, after any judgement above.
    if (i_note) begin
      w_state_nx = LANE_ACTIVE;
      w_c_nx     = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= LANE_IDLE;
      r_c     <= '0;
      r_res   <= '0;
    end else if (i_clr) begin
      r_state <= LANE_IDLE;
      r_c     <= '0;
      r_res   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_c     <= w_c_nx;
      r_res   <= w_res;
    end
  end

  assign o_res = r_res;

endmodule

// File: rtl/hit_judge.sv
// hit_judge: four-lane timing judge for a rhythm game.
// A prescaler produces a judgement tick every TICK_DIV cycles; each lane
// times its note in ticks and grades the press as PERFECT/GOOD/MISS.
// Pulses are accumulated one cycle later into a saturating score/combo.
// Ports:
//   CLK, RST_N       clock, async active-low reset (sync deassert)
//   CLR              synchronous game restart, highest priority
//   BTN[3:0]         per-lane press pulses
//   NOTE_VALID/LANE  note issue strobe and its lane
//   HIT_PERF/GOOD/MISS[3:0]  registered per-lane result pulses
//   SCORE[15:0], COMBO[9:0]  accumulated score and current combo
module hit_judge
  import hit_judge_pkg::*;
#(
  parameter int TICK_DIV = 100000,
  parameter int PERF_W   = 30,
  parameter int GOOD_W   = 80
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         CLR,
  input  logic [3:0]   BTN,
  input  logic         NOTE_VALID,
  input  logic [1:0]   NOTE_LANE,
  output logic [3:0]   HIT_PERF,
  output logic [3:0]   HIT_GOOD,
  output logic [3:0]   HIT_MISS,
  output logic [15:0]  SCORE,
  output logic [9:0]   COMBO
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW    = ($clog2(2 * GOOD_W + 1) > 8) ? $clog2(2 * GOOD_W + 1) : 8;

  // ---------------- prescaler ----------------
  logic [DIV_W-1:0] r_div;
  logic             w_tick;

  assign w_tick = (r_div == DIV_W'(TICK_DIV - 1));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)              r_div <= '0;
    else if (CLR || w_tick)  r_div <= '0;
    else                     r_div <= r_div + 1'b1;
  end

  // ---------------- lanes ----------------
  judge_t [NUM_LANES-1:0] w_res;

  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    logic w_note;
    assign w_note = NOTE_VALID && (NOTE_LANE == 2'(gi));

    hit_lane #(
      .PERF_W (PERF_W),
      .GOOD_W (GOOD_W),
      .CW     (CW)
    ) u_lane (
      .i_clk   (CLK),
      .i_rst_n (RST_N),
      .i_clr   (CLR),
      .i_tick  (w_tick),
      .i_btn   (BTN[gi]),
      .i_note  (w_note),
      .o_res   (w_res[gi])
    );

    assign HIT_PERF[gi] = w_res[gi].perf;
    assign HIT_GOOD[gi] = w_res[gi].good;
    assign HIT_MISS[gi] = w_res[gi].miss;
  end

  // ---------------- score / combo ----------------
  logic [SCORE_W-1:0] r_score, w_score_nx;
  logic [COMBO_W-1:0] r_combo, w_combo_nx;
  logic [2:0]         w_np, w_ng, w_nm;
  logic [4:0]         w_pts;
  logic [3:0]         w_hits;
  logic [SCORE_W:0]   w_score_sum;
  logic [COMBO_W:0]   w_combo_sum;

  assign w_np   = popcnt4(HIT_PERF);
  assign w_ng   = popcnt4(HIT_GOOD);
  assign w_nm   = popcnt4(HIT_MISS);
  assign w_pts  = 5'(PTS_PERF) * {2'b00, w_np} + 5'(PTS_GOOD) * {2'b00, w_ng}
                + 5'(PTS_MISS) * {2'b00, w_nm};
  assign w_hits = {1'b0, w_np} + {1'b0, w_ng};

  assign w_score_sum = {1'b0, r_score} + (SCORE_W + 1)'(w_pts);
  assign w_combo_sum = {1'b0, r_combo} + (COMBO_W + 1)'(w_hits);

  assign w_score_nx = (w_score_sum > {1'b0, SCORE_MAX}) ? SCORE_MAX
                                                        : w_score_sum[SCORE_W-1:0];
  // Any miss in the cycle breaks the combo, even alongside hits.
  assign w_combo_nx = (w_nm != 3'd0) ? '0
                    : (w_combo_sum > {1'b0, COMBO_MAX}) ? COMBO_MAX
                    : w_combo_sum[COMBO_W-1:0];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_score <= '0;
      r_combo <= '0;
    end else if (CLR) begin
      r_score <= '0;
      r_combo <= '0;
    end else begin
      r_score <= w_score_nx;
      r_combo <= w_combo_nx;
    end
  end

  assign SCORE = r_score;
  assign COMBO = r_combo;

endmodule

// File: tb/tb_hit_judge.sv
// tb_hit_judge: directed scenarios plus random stimulus for hit_judge.
// The reference model times each note by absolute tick numbers
// (ticks elapsed = ticks up to now minus ticks up to the issue edge)
// and grades presses from the window rules directly.
module tb_hit_judge;

  localparam int TD = 4;
  localparam int PW = 3;
  localparam int GW = 8;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b1;
  logic        CLR = 1'b0;
  logic [3:0]  BTN = '0;
  logic        NOTE_VALID = 1'b0;
  logic [1:0]  NOTE_LANE = '0;
  logic [3:0]  HIT_PERF, HIT_GOOD, HIT_MISS;
  logic [15:0] SCORE;
  logic [9:0]  COMBO;

  hit_judge #(.TICK_DIV(TD), .PERF_W(PW), .GOOD_W(GW)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .CLR        (CLR),
    .BTN        (BTN),
    .NOTE_VALID (NOTE_VALID),
    .NOTE_LANE  (NOTE_LANE),
    .HIT_PERF   (HIT_PERF),
    .HIT_GOOD   (HIT_GOOD),
    .HIT_MISS   (HIT_MISS),
    .SCORE      (SCORE),
    .COMBO      (COMBO)
  );

  always #5 CLK = ~CLK;

  int nchk = 0;
  int nerr = 0;
  bit run  = 1'b0;

  task automatic chk(input string nm, input int a, input int x);
    nchk++;
    if (a != x) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, a, x, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int         mk = 0;          // edge index since reset/restart
  bit         mact [4];
  int         me   [4];        // edge index at which the note was issued
  logic [3:0] ep = '0, eg = '0, em = '0;
  int         es = 0, ec = 0;

  // Number of tick edges among edges 0..x.
  function automatic int tcnt(input int x);
    return (x + 1) / TD;
  endfunction

  always @(posedge CLK or negedge RST_N) begin : model
    int pts, hits, c, err;
    logic [3:0] np, ng, nm;
    bit tick;
    if (!RST_N || CLR) begin
      mk = 0; ep = '0; eg = '0; em = '0; es = 0; ec = 0;
      for (int i = 0; i < 4; i++) mact[i] = 1'b0;
    end else begin
      pts  = 3 * $countones(ep) + $countones(eg);
      hits = $countones(ep) + $countones(eg);
      es   = (es + pts > 65535) ? 65535 : es + pts;
      ec   = (em != 0) ? 0 : ((ec + hits > 999) ? 999 : ec + hits);
      tick = (mk % TD) == TD - 1;
      np = '0; ng = '0; nm = '0;
      for (int i = 0; i < 4; i++) begin
        if (mact[i]) begin
          c   = tcnt(mk - 1) - tcnt(me[i]);
          err = (c > GW) ? c - GW : GW - c;
          if (BTN[i]) begin
            if (err <= PW) np[i] = 1'b1; else ng[i] = 1'b1;
            mact[i] = 1'b0;
          end else if (NOTE_VALID && int'(NOTE_LANE) == i) begin
            nm[i] = 1'b1;
          end else if (tick && c == 2 * GW) begin
            nm[i] = 1'b1;
            mact[i] = 1'b0;
          end
        end
        if (NOTE_VALID && int'(NOTE_LANE) == i) begin
          mact[i] = 1'b1;
          me[i]   = mk;
        end
      end
      ep = np; eg = ng; em = nm;
      mk++;
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge CLK) begin
    if (run) begin
      chk("perf", HIT_PERF, ep);
      chk("good", HIT_GOOD, eg);
      chk("miss", HIT_MISS, em);
      chk("score", SCORE, es);
      chk("combo", COMBO, ec);
    end
  end

  // ---------------- stimulus ----------------
  // Called at a negedge; the following posedge samples the inputs and the
  // task returns at the next negedge with that edge's results visible.
  task automatic cyc(input logic clr, input logic [3:0] btn,
                     input logic nv, input logic [1:0] nl);
    CLR = clr; BTN = btn; NOTE_VALID = nv; NOTE_LANE = nl;
    @(negedge CLK);
    CLR = 1'b0; BTN = '0; NOTE_VALID = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 4'h0, 1'b0, 2'd0);
  endtask

  task automatic note(input logic [1:0] l);
    cyc(1'b0, 4'h0, 1'b1, l);
  endtask

  task automatic press(input logic [3:0] b);
    cyc(1'b0, b, 1'b0, 2'd0);
  endtask

  task automatic restart;
    cyc(1'b1, 4'h0, 1'b0, 2'd0);
  endtask

  initial begin
    #2 RST_N = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_perf", HIT_PERF, 0);
    chk("rst_score", SCORE, 0);
    chk("rst_combo", COMBO, 0);
    RST_N = 1'b1;
    run = 1'b1;

    // Lane 0 PERFECT at C=8 (C at edge k after note at k=0 is k/4).
    restart; note(2'd0); idle(31); press(4'b0001);
    chk("l0_perf", HIT_PERF, 4'b0001);
    idle(1);
    chk("l0_perf_off", HIT_PERF, 0);
    chk("l0_score", SCORE, 3);
    chk("l0_combo", COMBO, 1);

    // Lane 1 GOOD at C=12 and at C=16.
    restart; note(2'd1); idle(47); press(4'b0010);
    chk("l1_good12", HIT_GOOD, 4'b0010);
    restart; note(2'd1); idle(63); press(4'b0010);
    chk("l1_good16", HIT_GOOD, 4'b0010);

    // Lane 1 MISS on the tick after C=16; combo broken.
    restart; note(2'd1); note(2'd0); press(4'b0001); idle(64);
    chk("l1_nomiss_yet", HIT_MISS, 0);
    idle(1);
    chk("l1_miss", HIT_MISS, 4'b0010);
    idle(1);
    chk("l1_combo0", COMBO, 0);
    chk("l1_score", SCORE, 1);

    // All four lanes PERFECT together.
    restart; note(2'd0); note(2'd1); note(2'd2); note(2'd3); idle(31);
    press(4'b1111);
    chk("all_perf", HIT_PERF, 4'b1111);
    idle(1);
    chk("all_score", SCORE, 12);
    chk("all_combo", COMBO, 4);

    // PERFECT on lane 2 with MISS on lane 3 in the same cycle.
    restart; note(2'd3); note(2'd0); press(4'b0001); idle(33);
    note(2'd2); idle(30); press(4'b0100);
    chk("mix_perf", HIT_PERF, 4'b0100);
    chk("mix_miss", HIT_MISS, 4'b1000);
    idle(1);
    chk("mix_score", SCORE, 4);
    chk("mix_combo", COMBO, 0);

    // New note on an active lane, then PERFECT 8 ticks later; idle press.
    restart; note(2'd0); idle(9); note(2'd0);
    chk("renote_miss", HIT_MISS, 4'b0001);
    idle(29); press(4'b0001);
    chk("renote_perf", HIT_PERF, 4'b0001);
    press(4'b0010);
    chk("idle_press", int'(HIT_PERF | HIT_GOOD | HIT_MISS), 0);

    // Drive score to 65534 and combo to 998, then saturate both.
    restart; note(2'd0);
    repeat (64536) cyc(1'b0, 4'b0001, 1'b1, 2'd0);
    note(2'd0);
    repeat (998) cyc(1'b0, 4'b0001, 1'b1, 2'd0);
    idle(1);
    chk("pre_score", SCORE, 65534);
    chk("pre_combo", COMBO, 998);
    note(2'd1); idle(32); press(4'b0011);
    chk("sat_perf", HIT_PERF, 4'b0011);
    idle(1);
    chk("sat_score", SCORE, 65535);
    chk("sat_combo", COMBO, 999);

    // Asynchronous reset while a pulse is up and a note is in flight.
    note(2'd3); note(2'd2); press(4'b0100);
    chk("pre_rst_good", HIT_GOOD, 4'b0100);
    #2 RST_N = 1'b0;
    #1;
    chk("arst_hits", int'(HIT_PERF | HIT_GOOD | HIT_MISS), 0);
    chk("arst_score", SCORE, 0);
    chk("arst_combo", COMBO, 0);
    @(negedge CLK); @(negedge CLK);
    RST_N = 1'b1;
    press(4'b1100);
    chk("post_rst_hits", int'(HIT_PERF | HIT_GOOD | HIT_MISS), 0);
    idle(1);
    chk("post_rst_score", SCORE, 0);

    // Random traffic.
    restart;
    for (int n = 0; n < 4000; n++) begin
      logic [3:0] b;
      b = '0;
      for (int j = 0; j < 4; j++) b[j] = ($urandom_range(0, 24) == 0);
      cyc($urandom_range(0, 999) == 0, b, $urandom_range(0, 5) == 0,
          2'($urandom_range(0, 3)));
    end

    run = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/hit_judge.md
HIT_JUDGE -- requirements
Module: hit_judge

Interface
REQ-001 SHALL have parameter TICK_DIV, default 100000, the number of CLK cycles per judgement tick (1 ms at 100 MHz).
REQ-002 SHALL have parameter PERF_W, default 30, the PERFECT half-window in ticks.
REQ-003 SHALL have parameter GOOD_W, default 80, the GOOD half-window in ticks, with GOOD_W > PERF_W.
REQ-004 SHALL have port CLK, input, 1 bit, the single system clock.
REQ-005 SHALL have port RST_N, input, 1 bit, an asynchronous active-low reset.
REQ-006 SHALL have port CLR, input, 1 bit, a synchronous game restart.
REQ-007 SHALL have port BTN, input, 4 bits, one single-cycle pulse per lane from the per-lane debounce stage.
REQ-008 SHALL have port NOTE_VALID, input, 1 bit, a one-cycle note issue strobe.
REQ-009 SHALL have port NOTE_LANE, input, 2 bits, the lane of the issued note.
REQ-010 SHALL have port HIT_PERF, output, 4 bits, a per-lane PERFECT pulse.
REQ-011 SHALL have port HIT_GOOD, output, 4 bits, a per-lane GOOD pulse.
REQ-012 SHALL have port HIT_MISS, output, 4 bits, a per-lane MISS pulse.
REQ-013 SHALL have port SCORE, output, 16 bits, the accumulated score.
REQ-014 SHALL have port COMBO, output, 10 bits, the current combo.

Function
REQ-015 SHALL have a free-running prescaler that asserts tick for 1 cycle every TICK_DIV cycles.
REQ-016 SHALL restart the prescaler on CLR.
REQ-017 SHALL define the note issue time as GOOD_W ticks before that note's target time.
REQ-018 SHALL run one FSM per lane, with states IDLE and ACTIVE and a tick counter C of 8 bits or more.
REQ-019 SHALL move a lane IDLE->ACTIVE with C=0 when NOTE_VALID is high and NOTE_LANE matches that lane.
REQ-020 SHALL increment C by one in ACTIVE on each tick.
REQ-021 SHALL judge a BTN pulse in ACTIVE using E = |C - GOOD_W|.
REQ-022 SHALL pulse HIT_PERF for that lane if E <= PERF_W, and otherwise pulse HIT_GOOD.
REQ-023 SHALL return the lane to IDLE after any judgement.
REQ-024 SHALL pulse HIT_MISS and return to IDLE when a tick arrives in ACTIVE while C = 2*GOOD_W.
REQ-025 SHALL therefore treat a press at C = 2*GOOD_W as a GOOD.
REQ-026 SHALL ignore a BTN pulse in IDLE, with no output and no penalty.
REQ-027 SHALL judge the press first when press and tick coincide in the same cycle.
REQ-028 SHALL, when a new note arrives for an ACTIVE lane, pulse HIT_MISS for the old note and restart at C=0 in the same cycle.
REQ-029 SHALL judge old note and restart at C=0 in the same cycle when press and new note coincide on an ACTIVE lane.
REQ-030 SHALL make hit pulses registered and 1 cycle long, asserted in cycle N+1 for BTN or NOTE sampled at edge N.
REQ-031 SHALL make at most one of HIT_PERF, HIT_GOOD and HIT_MISS high per lane per cycle.
REQ-032 SHALL judge all lanes independently in the same cycle.
REQ-033 SHALL update SCORE and COMBO in cycle N+2 from the pulses of cycle N+1.
REQ-034 SHALL increase SCORE by 3 per PERFECT and 1 per GOOD, summed over lanes in a cycle.
REQ-035 SHALL saturate SCORE at 65535.
REQ-036 SHALL set COMBO to 0 in any cycle with a MISS, even if hits occur in the same cycle.
REQ-037 SHALL otherwise increase COMBO by the number of PERFECT plus GOOD pulses in that cycle.
REQ-038 SHALL saturate COMBO at 999.
REQ-039 SHALL, on CLR, set all lanes to IDLE and clear SCORE, COMBO and all pulses on the next edge.
REQ-040 SHALL give CLR priority over all other inputs in the same cycle.

Reset
REQ-041 SHALL, while RST_N is low, immediately force all lanes to IDLE with C=0.
REQ-042 SHALL, while RST_N is low, immediately force the prescaler to 0.
REQ-043 SHALL, while RST_N is low, immediately force HIT_PERF, HIT_GOOD and HIT_MISS to 4'b0000.
REQ-044 SHALL, while RST_N is low, immediately force SCORE to 0 and COMBO to 0.
REQ-045 SHALL discard any note or press in flight at reset without generating a pulse.
REQ-046 SHALL require RST_N deassertion to be synchronous to CLK, supplied by an external reset synchroniser.

Structure
REQ-047 SHALL place the lane-state encoding, the point values (3, 1, 0) and the saturation limits (65535, 999) in a shared package, hit_judge_pkg.
REQ-048 SHALL implement one sub-module, hit_lane, holding a single lane FSM and counter, instantiated 4 times.
REQ-049 SHALL keep the prescaler and the score/combo accumulator in hit_judge.

Verification (TICK_DIV=4, PERF_W=3, GOOD_W=8)
REQ-050 SHALL check: note on lane 0, press at C=8 -> HIT_PERF[0] high for 1 cycle, then SCORE=3 and COMBO=1.
REQ-051 SHALL check: note on lane 1, press at C=12 -> HIT_GOOD[1]; press at C=16 -> HIT_GOOD[1]; no press -> HIT_MISS[1] on the tick after C=16, then COMBO=0.
REQ-052 SHALL check: lanes 0..3 all PERFECT in the same cycle -> SCORE rises by 12 and COMBO by 4 in one update.
REQ-053 SHALL check: PERFECT on lane 2 and MISS on lane 3 in the same cycle -> SCORE +3, COMBO=0.
REQ-054 SHALL check: new note on ACTIVE lane 0 -> HIT_MISS[0] pulse, then press 8 ticks later -> HIT_PERF[0]; press on an IDLE lane -> no output.
REQ-055 SHALL check: preload SCORE=65534 and COMBO=998, then 2 PERFECTs -> SCORE=65535 and COMBO=999; RST_N low mid-note -> all outputs 0 asynchronously, with no pulse after release.
